la_pattern_ctrl: RTL and testbench
==================================

Name: la_pattern_ctrl

Overview:
- Burst sequencer for the logic-analyzer test-pattern source.
- Accepts a start command with mode, burst length and sample rate, then drives an 8-bit pattern stream with a valid strobe.
- Pattern is one of: 8-bit LFSR, up-counter, walking-one or constant.
- Reports busy/done to the capture/control logic. Sits between the LA control registers and the capture input used for self-test.

Parameters:
- LEN_W, 16, width of burst_len and of the internal sample counter.
- DIV_W, 8, width of rate and of the internal rate divider.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset
- start  in  1  single-cycle command; honoured only in IDLE
- stop  in  1  abort request; honoured only in RUN
- mode  in  2  0=LFSR, 1=counter, 2=walking-one, 3=constant
- burst_len  in  LEN_W  number of samples; 0 = continuous until stop
- rate  in  DIV_W  one sample every rate+1 cycles
- const_val  in  8  constant-mode value and counter start value
- test_data  out  8  current pattern sample, held between strobes
- data_valid  out  1  one-cycle strobe per sample
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at end of burst or abort

Interface rule: reset sys_rst_n, asynchronous, active-low; clock sys_clk.

Behaviour:
- Reset values: test_data=0x00, data_valid=0, busy=0, done=0; state IDLE; all counters 0. All outputs are registered.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE on the last sample or on stop.
  - DONE -> IDLE unconditionally after one cycle.
- Start:
  - On the edge where start=1 in IDLE, latch mode, burst_len, rate and const_val.
  - Preload the generators: LFSR=0x00, counter=const_val, walking-one=0x01.
  - Clear the divider and sample count. busy=1 from the next cycle.
- Sample timing:
  - First data_valid appears in the cycle after busy rises, i.e. 2 cycles after the start edge.
  - Later strobes follow every rate+1 cycles. rate=0 gives a strobe every cycle.
  - On each strobe, test_data = the current generator value; the generator then advances and the sample count increments.
- Generators:
  - LFSR: polynomial x^8+x^6+x^5+x^4+1, XNOR Galois form. With fb=q[7]:
    - n0=fb, n1=q0, n2=q1, n3=q2
    - n4=q3 XNOR fb, n5=q4 XNOR fb, n6=q5 XNOR fb, n7=q6
    - Advances only on strobe.
  - Counter: +1 modulo 256.
  - Walking-one: rotate left; 0x80 -> 0x01.
  - Constant: const_val, never changes.
- Burst end:
  - When the strobe for sample number burst_len (burst_len!=0) is issued, the next cycle is DONE: done=1, busy=0, data_valid=0.
  - test_data keeps the last sample.
- Stop:
  - stop=1 in RUN -> DONE next cycle.
  - stop has priority over a strobe due in the same cycle; that strobe is suppressed.
  - stop in IDLE or DONE is ignored.
- Other boundary conditions:
  - start while busy or in DONE is ignored (no queueing).
  - start and stop together in IDLE: start wins.
  - Latched parameters cannot change mid-burst; input changes take effect at the next start.
  - Continuous mode (burst_len=0): the sample counter saturates, no wrap-induced termination.
  - Asynchronous reset mid-burst: immediate return to reset values, no done pulse.

Decomposition:
- Shared package la_pkg holds:
  - Mode encodings: PAT_LFSR, PAT_CNT, PAT_WALK, PAT_CONST.
  - State encoding: ST_IDLE, ST_RUN, ST_DONE.
  - LFSR seed constant 8'h00.
- One sub-module: la_lfsr8_step.
  - Ports: clk, rst_n, clr, adv, q[7:0].
  - Synchronous clr loads the seed; adv advances one step.
  - Counter, walking-one and constant generators remain inline.

Test Plan:
- mode=0, burst_len=4, rate=0, start -> data_valid on 4 consecutive cycles with test_data 0x00, 0x70, 0x90, 0x21; then done=1 for 1 cycle; busy high exactly 5 cycles.
- mode=1, const_val=0xFE, burst_len=3, rate=2 -> strobes 3 cycles apart with 0xFE, 0xFF, 0x00; done one cycle after the last strobe.
- mode=2, burst_len=9, rate=0 -> 0x01, 0x02, ..., 0x80, 0x01 (9th sample wraps).
- mode=3, const_val=0xA5, burst_len=0, rate=1; stop after 5 strobes, asserted in the cycle a 6th strobe is due -> exactly 5 strobes of 0xA5, no 6th; done pulse next cycle.
- Second start pulsed while busy, and stop pulsed in IDLE -> no effect: sample count and done timing are identical to a run without them.
- Reset asserted mid-burst at sample 2 -> all outputs 0 immediately, no done pulse; a new start gives LFSR sequence 0x00, 0x70, 0x90, 0x21 again.

Source files
------------

// File: rtl/la_pkg.sv
// la_pkg: shared encodings for the logic-analyzer test-pattern source.
//   la_mode_e  : pattern generator select (matches the 2-bit mode input)
//   la_state_e : burst sequencer state, also exported as a debug output
//   LFSR_SEED  : value the LFSR is loaded with at every burst start
package la_pkg;

  typedef enum logic [1:0] {
    PAT_LFSR  = 2'd0,
    PAT_CNT   = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_CONST = 2'd3
  } la_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } la_state_e;

  localparam logic [7:0] LFSR_SEED = 8'h00;

endpackage

// File: rtl/la_lfsr8_step.sv
// la_lfsr8_step: 8-bit XNOR Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (q resets to the seed)
//   clr        : synchronous load of LFSR_SEED (wins over adv)
//   adv        : advance one step
//   q          : current LFSR value
module la_lfsr8_step
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;
  logic       fb;

  // XNOR taps make the all-zero word a legal state, so the seed 0x00
  // does not lock up.
  always_comb begin
    fb  = q_q[7];
    q_d = q_q;
    if (clr) begin
      q_d = LFSR_SEED;
    end else if (adv) begin
      q_d = {q_q[6], q_q[5] ~^ fb, q_q[4] ~^ fb, q_q[3] ~^ fb,
             q_q[2], q_q[1], q_q[0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= LFSR_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/la_pattern_ctrl.sv
// la_pattern_ctrl: burst sequencer for the logic-analyzer test-pattern source.
// A start command in IDLE latches mode/burst_len/rate/const_val and runs a
// burst of 8-bit samples (LFSR, up-counter, walking-one or constant).
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start, stop        : start command (IDLE only), abort (RUN only)
//   mode, burst_len    : pattern select, samples per burst (0 = continuous)
//   rate, const_val    : strobe every rate+1 cycles, constant/counter start
//   test_data          : last issued sample, held between strobes
//   data_valid         : one-cycle strobe per sample
//   busy, done         : high in RUN, one-cycle pulse on leaving RUN
//   dbg_state          : sequencer state
// Stream semantics: there is no back-pressure. data_valid is a one-cycle
// strobe; test_data is meaningful in the cycle data_valid is high and is
// held afterwards. All outputs are registered.
module la_pattern_ctrl
  import la_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [DIV_W-1:0] rate,
  input  logic [7:0]       const_val,
  output logic [7:0]       test_data,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output la_state_e        dbg_state
);

  la_state_e        state_q, state_d;
  la_mode_e         mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
  logic [DIV_W-1:0] rate_q, rate_d, div_q, div_d;
  logic [7:0]       const_q, const_d, cnt_q, cnt_d, walk_q, walk_d;
  logic [7:0]       test_data_q, test_data_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lfsr_clr, strobe;
  logic [7:0]       lfsr_q, gen_val;

  la_lfsr8_step u_lfsr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (lfsr_clr),
    .adv   (strobe),
    .q     (lfsr_q)
  );

  always_comb begin
    case (mode_q)
      PAT_LFSR: gen_val = lfsr_q;
      PAT_CNT:  gen_val = cnt_q;
      PAT_WALK: gen_val = walk_q;
      default:  gen_val = const_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    rate_d       = rate_q;
    const_d      = const_q;
    count_d      = count_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    walk_d       = walk_q;
    test_data_d  = test_data_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lfsr_clr     = 1'b0;
    strobe       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          mode_d   = la_mode_e'(mode);
          len_d    = burst_len;
          rate_d   = rate;
          const_d  = const_val;
          count_d  = '0;
          div_d    = '0;
          cnt_d    = const_val;
          walk_d   = 8'h01;
          lfsr_clr = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        // Divider free-runs 0..rate; a strobe is due whenever it reads 0,
        // so the first strobe comes one cycle after entering RUN.
        div_d = (div_q == rate_q) ? '0 : div_q + 1'b1;
        // The cycle after the final strobe (count already equals len) ends
        // the burst; stop takes precedence over a strobe due now.
        if (stop || ((len_q != '0) && (count_q == len_q))) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (div_q == '0) begin
          strobe       = 1'b1;
          data_valid_d = 1'b1;
          test_data_d  = gen_val;
          // Saturate so continuous bursts never terminate on wrap.
          count_d      = (count_q == '1) ? count_q : count_q + 1'b1;
          cnt_d        = cnt_q + 8'd1;
          walk_d       = {walk_q[6:0], walk_q[7]};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= PAT_LFSR;
      len_q        <= '0;
      rate_q       <= '0;
      const_q      <= '0;
      count_q      <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      walk_q       <= '0;
      test_data_q  <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      rate_q       <= rate_d;
      const_q      <= const_d;
      count_q      <= count_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      walk_q       <= walk_d;
      test_data_q  <= test_data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign test_data  = test_data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_la_pattern_ctrl.sv
// Testbench for la_pattern_ctrl: behavioural burst model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_la_pattern_ctrl;
  import la_pkg::*;

  localparam int LEN_W = 16;
  localparam int DIV_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [DIV_W-1:0] rate = '0;
  logic [7:0]       const_val = 8'h00;
  logic [7:0]       test_data;
  logic             data_valid, busy, done;
  la_state_e        dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  la_pattern_ctrl #(.LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .burst_len  (burst_len),
    .rate       (rate),
    .const_val  (const_val),
    .test_data  (test_data),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 running, 2 done. k counts cycles since the start edge;
  // strobes land on k = 1, 1+(rate+1), 1+2(rate+1), ...
  int         m_phase = 0, m_k = 0, m_n = 0, m_len = 0, m_rate = 0;
  logic [1:0] m_mode = 2'd0;
  logic [7:0] m_const = 8'h00, m_lfsr = 8'h00;
  logic [7:0] e_td = 8'h00;
  logic       e_dv = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic fb;
    fb = q[7];
    return {q[6:0], fb} ^ ({8{~fb}} & 8'h70);
  endfunction

  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_phase = 0; e_td = 8'h00; e_dv = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_dv = 1'b0;
      e_done = 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_k = 0; m_n = 0; m_lfsr = 8'h00;
          m_mode = mode; m_len = int'(burst_len); m_rate = int'(rate); m_const = const_val;
          e_busy = 1'b1;
        end
      end else if (m_phase == 1) begin
        m_k++;
        if (stop || (m_len != 0 && m_n == m_len)) begin
          m_phase = 2; e_busy = 1'b0; e_done = 1'b1;
        end else if ((m_k - 1) % (m_rate + 1) == 0) begin
          e_dv = 1'b1;
          case (m_mode)
            2'd0: begin e_td = m_lfsr; m_lfsr = lfsr_next(m_lfsr); end
            2'd1: e_td = m_const + 8'(m_n);
            2'd2: e_td = 8'h01 << (m_n % 8);
            default: e_td = m_const;
          endcase
          m_n++;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- compare process + log ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         strobe_cyc[$];
  int         busy_cnt = 0, done_cnt = 0, done_cyc = 0;

  initial forever begin
    @(negedge sys_clk);
    if (sys_rst_n) begin
      chk("outputs{td,dv,busy,done}", {21'd0, test_data, data_valid, busy, done},
          {21'd0, e_td, e_dv, e_busy, e_done});
      if (data_valid) begin
        got_q.push_back(test_data);
        strobe_cyc.push_back(cyc);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic clear_log();
    got_q.delete();
    strobe_cyc.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  // Pulses start for one cycle, then scrambles the inputs so that only the
  // latched values can explain the burst.
  task automatic run_burst(input logic [1:0] m, input int len, input int r,
                           input logic [7:0] cv, input logic with_stop);
    @(negedge sys_clk);
    mode = m; burst_len = LEN_W'(len); rate = DIV_W'(r); const_val = cv;
    start = 1'b1; stop = with_stop;
    @(negedge sys_clk);
    start = 1'b0; stop = 1'b0;
    start_cyc = cyc;
    mode = 2'($urandom); burst_len = LEN_W'($urandom); rate = DIV_W'($urandom);
    const_val = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (done) break;
    end
    chk("done_within_budget", i < budget, 1);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int s = 0;
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (data_valid) s++;
      if (s == n) break;
    end
    chk("strobes_within_budget", i < budget, 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_sample"}, got_q[i], exp_q[i]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(negedge sys_clk);
    chk("reset_outputs", {test_data, data_valid, busy, done}, 11'd0);
    chk("reset_state", dbg_state, ST_IDLE);
    sys_rst_n = 1'b1;
    settle();

    // LFSR burst of 4 back-to-back samples
    clear_log();
    run_burst(2'd0, 4, 0, 8'h33, 1'b0);
    wait_done(40);
    settle();
    exp_q = '{8'h00, 8'h70, 8'h90, 8'h21};
    check_seq("lfsr4");
    chk("lfsr4_first_latency", strobe_cyc[0] - start_cyc, 1);
    chk("lfsr4_busy_cycles", busy_cnt, 5);
    chk("lfsr4_done_pulses", done_cnt, 1);

    // Counter wrapping through 0xFF, rate 2
    clear_log();
    run_burst(2'd1, 3, 2, 8'hFE, 1'b0);
    wait_done(60);
    settle();
    exp_q = '{8'hFE, 8'hFF, 8'h00};
    check_seq("cnt3");
    chk("cnt3_gap1", strobe_cyc[1] - strobe_cyc[0], 3);
    chk("cnt3_gap2", strobe_cyc[2] - strobe_cyc[1], 3);
    chk("cnt3_done_after_last", done_cyc - strobe_cyc[2], 1);

    // Walking one, 9 samples; stop with start in IDLE must be ignored
    clear_log();
    run_burst(2'd2, 9, 0, 8'h00, 1'b1);
    wait_done(60);
    settle();
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    check_seq("walk9");
    chk("walk9_done_pulses", done_cnt, 1);

    // Continuous constant, stopped exactly when the 6th strobe is due
    clear_log();
    run_burst(2'd3, 0, 1, 8'hA5, 1'b0);
    wait_strobes(5, 40);
    @(negedge sys_clk);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    settle();
    exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    check_seq("const_stop");
    chk("const_stop_done_pulses", done_cnt, 1);
    chk("const_stop_done_timing", done_cyc - strobe_cyc[4], 2);

    // Stop in IDLE, start while busy, start/stop in DONE: all ignored
    @(negedge sys_clk);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    clear_log();
    run_burst(2'd0, 4, 0, 8'h00, 1'b0);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(40);
    start = 1'b1; stop = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; stop = 1'b0;
    repeat (6) @(negedge sys_clk);
    exp_q = '{8'h00, 8'h70, 8'h90, 8'h21};
    check_seq("ignored_cmds");
    chk("ignored_busy_cycles", busy_cnt, 5);
    chk("ignored_done_pulses", done_cnt, 1);

    // Asynchronous reset mid-burst, then a clean rerun
    clear_log();
    run_burst(2'd0, 4, 0, 8'h00, 1'b0);
    wait_strobes(2, 20);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {test_data, data_valid, busy, done}, 11'd0);
    chk("midreset_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_log();
    repeat (6) @(negedge sys_clk);
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_no_busy", busy_cnt, 0);
    clear_log();
    run_burst(2'd0, 4, 0, 8'h00, 1'b0);
    wait_done(40);
    settle();
    exp_q = '{8'h00, 8'h70, 8'h90, 8'h21};
    check_seq("after_reset");

    // Random traffic: model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      mode      = 2'($urandom_range(0, 3));
      burst_len = LEN_W'($urandom_range(0, 8));
      rate      = DIV_W'($urandom_range(0, 3));
      const_val = 8'($urandom);
    end
    @(negedge sys_clk);
    start = 1'b0;
    stop = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
